// File: rtl/sdram_burst_arb_if.sv
// Arbiter <-> SDRAM controller / FIFO status bundle for sdram_burst_arb.
// master: the arbiter (drives burst requests); slave: the controller/environment side.
interface sdram_burst_arb_if;
    localparam int unsigned USE_W  = 9;
    localparam int unsigned ADDR_W = 22;

    logic              frame_sync;
    logic [USE_W-1:0]  wrf_use;
    logic [USE_W-1:0]  rdf_use;
    logic              sdram_ack;
    logic              sdram_done;
    logic              sys_wr_req;
    logic              sys_rd_req;
    logic [ADDR_W-1:0] sys_addr;
    logic              busy;

    modport master (
        input  frame_sync,
        input  wrf_use,
        input  rdf_use,
        input  sdram_ack,
        input  sdram_done,
        output sys_wr_req,
        output sys_rd_req,
        output sys_addr,
        output busy
    );

    modport slave (
        output frame_sync,
        output wrf_use,
        output rdf_use,
        output sdram_ack,
        output sdram_done,
        input  sys_wr_req,
        input  sys_rd_req,
        input  sys_addr,
        input  busy
    );
endinterface

// File: rtl/sdram_burst_arb.sv
// Burst arbiter between a capture write FIFO and a display read FIFO sharing one
// SDRAM. Frames are double-buffered in two banks; capture writes one bank while
// display reads the most recently completed one.
module sdram_burst_arb #(
    parameter int unsigned BURST       = 160,
    parameter int unsigned FRAME_WORDS = 76800,
    parameter int unsigned RD_LOW      = 64,
    parameter int unsigned RD_DEPTH    = 512
) (
    input  logic               clk,
    input  logic               rst,
    sdram_burst_arb_if.master  bus
);
    localparam int unsigned OFS_W  = 21;
    localparam int unsigned ADDR_W = OFS_W + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_wr_req;
    logic               r_rd_req;
    logic               r_busy;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic [OFS_W-1:0]   r_wr_ofs;
    logic [OFS_W-1:0]   r_rd_ofs;
    logic               r_pend;
    logic               r_fs_d;
    logic               r_last_wr;

    logic               w_fs_rise;
    logic               w_wr_ready;
    logic               w_rd_ready;
    logic               w_rd_urgent;
    logic               w_wr_bank_cur;
    logic [OFS_W-1:0]   w_wr_ofs_cur;
    logic [OFS_W-1:0]   w_wr_ofs_inc;
    logic [OFS_W-1:0]   w_rd_ofs_inc;
    logic               w_wr_wrap;
    logic               w_rd_wrap;
    logic               w_grant_wr;
    logic               w_grant_rd;

    assign w_fs_rise   = bus.frame_sync & ~r_fs_d;
    assign w_wr_ready  = (32'(bus.wrf_use) >= BURST);
    assign w_rd_ready  = (32'(bus.rdf_use) <= (RD_DEPTH - BURST));
    assign w_rd_urgent = (32'(bus.rdf_use) <  RD_LOW);

    // A pending frame switch is applied in IDLE before the grant, so the grant
    // address must already reflect the new bank and cleared offset.
    assign w_wr_bank_cur = r_pend ? ~r_wr_bank : r_wr_bank;
    assign w_wr_ofs_cur  = r_pend ? '0 : r_wr_ofs;

    // Offsets wrap by explicit compare; the bank bit is never touched by a carry.
    assign w_wr_ofs_inc = r_wr_ofs + OFS_W'(BURST);
    assign w_rd_ofs_inc = r_rd_ofs + OFS_W'(BURST);
    assign w_wr_wrap    = (w_wr_ofs_inc == OFS_W'(FRAME_WORDS));
    assign w_rd_wrap    = (w_rd_ofs_inc == OFS_W'(FRAME_WORDS));

    // Grant priority: urgent read, then alternate when both ready, then whichever is ready.
    always_comb begin
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        if (w_rd_urgent) begin
            w_grant_rd = 1'b1;
        end else if (w_wr_ready && w_rd_ready) begin
            if (r_last_wr) begin
                w_grant_rd = 1'b1;
            end else begin
                w_grant_wr = 1'b1;
            end
        end else if (w_wr_ready) begin
            w_grant_wr = 1'b1;
        end else if (w_rd_ready) begin
            w_grant_rd = 1'b1;
        end
    end

    // Arbiter FSM with registered request/address/busy outputs and frame pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wr_req  <= 1'b0;
            r_rd_req  <= 1'b0;
            r_busy    <= 1'b0;
            r_addr    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b1;
            r_wr_ofs  <= '0;
            r_rd_ofs  <= '0;
            r_pend    <= 1'b0;
            r_fs_d    <= 1'b0;
            r_last_wr <= 1'b0;
        end else begin
            r_fs_d <= bus.frame_sync;

            case (r_state)
                IDLE: begin
                    if (r_pend) begin
                        r_wr_bank <= ~r_wr_bank;
                        r_wr_ofs  <= '0;
                        r_pend    <= 1'b0;
                    end
                    if (w_grant_wr) begin
                        r_state   <= WR_REQ;
                        r_busy    <= 1'b1;
                        r_wr_req  <= 1'b1;
                        r_addr    <= {w_wr_bank_cur, w_wr_ofs_cur};
                        r_last_wr <= 1'b1;
                    end else if (w_grant_rd) begin
                        r_state   <= RD_REQ;
                        r_busy    <= 1'b1;
                        r_rd_req  <= 1'b1;
                        r_addr    <= {r_rd_bank, r_rd_ofs};
                        r_last_wr <= 1'b0;
                    end
                end

                WR_REQ: begin
                    if (bus.sdram_ack) begin
                        r_state  <= WR_WAIT;
                        r_wr_req <= 1'b0;
                    end
                end

                WR_WAIT: begin
                    if (bus.sdram_done) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_wr_ofs <= w_wr_wrap ? '0 : w_wr_ofs_inc;
                    end
                end

                RD_REQ: begin
                    if (bus.sdram_ack) begin
                        r_state  <= RD_WAIT;
                        r_rd_req <= 1'b0;
                    end
                end

                RD_WAIT: begin
                    if (bus.sdram_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        if (w_rd_wrap) begin
                            r_rd_ofs  <= '0;
                            r_rd_bank <= ~r_wr_bank;
                        end else begin
                            r_rd_ofs  <= w_rd_ofs_inc;
                        end
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                    r_wr_req <= 1'b0;
                    r_rd_req <= 1'b0;
                end
            endcase

            // A new edge always (re)arms the pending flag, overriding a same-cycle consume.
            if (w_fs_rise) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign bus.sys_wr_req = r_wr_req;
    assign bus.sys_rd_req = r_rd_req;
    assign bus.sys_addr   = r_addr;
    assign bus.busy       = r_busy;

    // Request strobes are mutually exclusive and only live in a REQ state.
    a_req_excl: assert property (@(posedge clk) disable iff (rst) !(r_wr_req && r_rd_req));
    a_wr_state: assert property (@(posedge clk) disable iff (rst) r_wr_req |-> (r_state == WR_REQ));
    a_rd_state: assert property (@(posedge clk) disable iff (rst) r_rd_req |-> (r_state == RD_REQ));
    a_busy:     assert property (@(posedge clk) disable iff (rst) r_busy == (r_state != IDLE));

endmodule

// File: tb/tb_sdram_burst_arb.sv
// Directed bench for sdram_burst_arb: priority, alternation, frame switching,
// pointer wrap and mid-burst reset, with hand-computed burst addresses.
module tb_sdram_burst_arb;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    sdram_burst_arb_if bus ();

    sdram_burst_arb #(
        .BURST       (160),
        .FRAME_WORDS (76800),
        .RD_LOW      (64),
        .RD_DEPTH    (512)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full burst: wait for a request, check it, ack, optionally inject
    // frame_sync pulses during the wait phase, then signal done.
    task automatic run_burst(input string tag, input logic exp_wr, input logic [21:0] exp_addr,
                             input int fs_pulses, input logic stray_done);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.sys_wr_req || bus.sys_rd_req) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check_eq({tag, "_wr"},   32'(bus.sys_wr_req), 32'(exp_wr));
            check_eq({tag, "_rd"},   32'(bus.sys_rd_req), 32'(!exp_wr));
            check_eq({tag, "_addr"}, 32'(bus.sys_addr),   32'(exp_addr));
            check_eq({tag, "_busy"}, 32'(bus.busy),       32'd1);
            if (stray_done) begin
                bus.sdram_done = 1'b1;
                @(negedge clk);
                bus.sdram_done = 1'b0;
                check_eq({tag, "_hold_req"},  32'(bus.sys_wr_req | bus.sys_rd_req), 32'd1);
                check_eq({tag, "_hold_addr"}, 32'(bus.sys_addr), 32'(exp_addr));
            end
            bus.sdram_ack = 1'b1;
            @(negedge clk);
            bus.sdram_ack = 1'b0;
            check_eq({tag, "_req_drop"}, 32'(bus.sys_wr_req | bus.sys_rd_req), 32'd0);
            check_eq({tag, "_wait_busy"}, 32'(bus.busy), 32'd1);
            for (int p = 0; p < fs_pulses; p++) begin
                bus.frame_sync = 1'b1;
                @(negedge clk);
                bus.frame_sync = 1'b0;
                @(negedge clk);
            end
            bus.sdram_done = 1'b1;
            @(negedge clk);
            bus.sdram_done = 1'b0;
            check_eq({tag, "_idle"}, 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic do_reset(input logic [8:0] wrf, input logic [8:0] rdf);
        @(negedge clk);
        rst            = 1'b1;
        bus.frame_sync = 1'b0;
        bus.sdram_ack  = 1'b0;
        bus.sdram_done = 1'b0;
        bus.wrf_use    = wrf;
        bus.rdf_use    = rdf;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        rst            = 1'b1;
        bus.frame_sync = 1'b0;
        bus.wrf_use    = 9'd0;
        bus.rdf_use    = 9'd400;
        bus.sdram_ack  = 1'b0;
        bus.sdram_done = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_wr",   32'(bus.sys_wr_req), 32'd0);
        check_eq("rst_rd",   32'(bus.sys_rd_req), 32'd0);
        check_eq("rst_busy", 32'(bus.busy),       32'd0);
        check_eq("rst_addr", 32'(bus.sys_addr),   32'd0);
        rst = 1'b0;

        // Nothing ready: stray ack/done in IDLE must not move the FSM
        @(negedge clk);
        bus.sdram_ack  = 1'b1;
        bus.sdram_done = 1'b1;
        @(negedge clk);
        bus.sdram_ack  = 1'b0;
        bus.sdram_done = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", 32'(bus.busy), 32'd0);
        check_eq("idle_req",  32'(bus.sys_wr_req | bus.sys_rd_req), 32'd0);

        // Plain write bursts advance by BURST
        bus.wrf_use = 9'd160;
        run_burst("w0", 1'b1, 22'h000000, 0, 1'b1);
        run_burst("w1", 1'b1, 22'h0000A0, 0, 1'b0);

        // Urgent read beats a ready write
        do_reset(9'd200, 9'd10);
        run_burst("urg", 1'b0, 22'h200000, 0, 1'b0);

        // Both ready, not urgent: alternate starting with write
        do_reset(9'd300, 9'd100);
        run_burst("alt0", 1'b1, 22'h000000, 0, 1'b0);
        run_burst("alt1", 1'b0, 22'h200000, 0, 1'b0);
        run_burst("alt2", 1'b1, 22'h0000A0, 0, 1'b0);
        run_burst("alt3", 1'b0, 22'h2000A0, 0, 1'b0);

        // frame_sync during a write is deferred; two edges while pending count once
        do_reset(9'd160, 9'd400);
        run_burst("fs0", 1'b1, 22'h000000, 1, 1'b0);
        run_burst("fs1", 1'b1, 22'h200000, 2, 1'b0);
        run_burst("fs2", 1'b1, 22'h000000, 0, 1'b0);

        // 480 writes fill one frame; offset wraps, bank unchanged
        do_reset(9'd160, 9'd400);
        for (int i = 0; i < 480; i++) begin
            run_burst("wwrap", 1'b1, 22'(i * 160), 0, 1'b0);
        end
        run_burst("wwrap_end", 1'b1, 22'h000000, 0, 1'b0);

        // Read wrap loads the completed bank (~wr_bank) after a frame switch
        do_reset(9'd0, 9'd400);
        bus.frame_sync = 1'b1;
        @(negedge clk);
        bus.frame_sync = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("fs_idle_busy", 32'(bus.busy), 32'd0);
        bus.rdf_use = 9'd300;
        for (int i = 0; i < 480; i++) begin
            run_burst("rwrap", 1'b0, 22'(32'h200000 + i * 160), 0, 1'b0);
        end
        run_burst("rwrap_end", 1'b0, 22'h000000, 0, 1'b0);

        // Reset while a read request is outstanding
        do_reset(9'd200, 9'd10);
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (bus.sys_rd_req) begin
                    seen = 1'b1;
                    break;
                end
            end
            check_eq("mid_rdreq", 32'(seen), 32'd1);
        end
        rst = 1'b1;
        #1;
        check_eq("mid_rst_wr",   32'(bus.sys_wr_req), 32'd0);
        check_eq("mid_rst_rd",   32'(bus.sys_rd_req), 32'd0);
        check_eq("mid_rst_busy", 32'(bus.busy),       32'd0);
        check_eq("mid_rst_addr", 32'(bus.sys_addr),   32'd0);
        bus.wrf_use = 9'd160;
        bus.rdf_use = 9'd400;
        @(negedge clk);
        rst = 1'b0;
        run_burst("post_rst", 1'b1, 22'h000000, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sdram_burst_arb.md
SDRAM_BURST_ARB -- requirements
Module: sdram_burst_arb

Interface
REQ-001 SHALL have parameter BURST, default 160: words per SDRAM burst (one video line of 16-bit words).
REQ-002 SHALL have parameter FRAME_WORDS, default 76800: words per frame bank; integer multiple of BURST.
REQ-003 SHALL have parameter RD_LOW, default 64: display-FIFO level below which a read is urgent.
REQ-004 SHALL have parameter RD_DEPTH, default 512: display-FIFO depth in words.
REQ-005 SHALL have ports clk (in, 1, system clock; all logic on rising edge, no other clock) and rst (in, 1, asynchronous active-high reset).
REQ-006 SHALL have port frame_sync (in, 1, capture vsync already synchronous to clk; level).
REQ-007 SHALL have port wrf_use (in, 9, words held in the capture write FIFO, read side).
REQ-008 SHALL have port rdf_use (in, 9, words held in the display read FIFO, write side).
REQ-009 SHALL have port sdram_ack (in, 1, one-cycle pulse: SDRAM controller accepted the current request).
REQ-010 SHALL have port sdram_done (in, 1, one-cycle pulse: accepted burst has completed).
REQ-011 SHALL have port sys_wr_req (out, 1, write-burst request).
REQ-012 SHALL have port sys_rd_req (out, 1, read-burst request).
REQ-013 SHALL have port sys_addr (out, 22, word address of the burst: {bank, 21-bit offset}).
REQ-014 SHALL have port busy (out, 1, high whenever the FSM state is not IDLE).

Function
REQ-015 SHALL use FSM states IDLE, WR_REQ, WR_WAIT, RD_REQ and RD_WAIT.
REQ-016 Write-ready SHALL be defined as wrf_use >= BURST.
REQ-017 Read-ready SHALL be defined as rdf_use <= RD_DEPTH-BURST; read-urgent SHALL be defined as rdf_use < RD_LOW.
REQ-018 In IDLE, the FSM SHALL go to RD_REQ on read-urgent; else to WR_REQ on write-ready; else to RD_REQ on read-ready; else stay in IDLE.
REQ-019 When write-ready and read-ready are both true and read is not urgent, the FSM SHALL grant the type not granted last, starting with write after reset.
REQ-020 In WR_REQ and RD_REQ, sys_wr_req or sys_rd_req respectively SHALL be high and sys_addr SHALL stay stable until the cycle in which sdram_ack is sampled high; the FSM SHALL then go to WR_WAIT or RD_WAIT.
REQ-021 sys_wr_req and sys_rd_req SHALL be registered outputs, never high in the same cycle, and low in every state other than WR_REQ and RD_REQ.
REQ-022 In WR_WAIT and RD_WAIT, the FSM SHALL wait for sdram_done and then return to IDLE; the next request SHALL be issued no earlier than 2 cycles after sdram_done.
REQ-023 sdram_ack SHALL be ignored outside the REQ states, and sdram_done SHALL be ignored outside the WAIT states.
REQ-024 The write pointer wr_ofs SHALL advance by BURST on each write done and wrap to 0 on reaching FRAME_WORDS; sys_addr for a write SHALL be {wr_bank, wr_ofs}.
REQ-025 The read pointer rd_ofs SHALL advance by BURST on each read done; on wrap to 0, rd_bank SHALL load ~wr_bank, the most recently completed bank. sys_addr for a read SHALL be {rd_bank, rd_ofs}.
REQ-026 A rising edge of frame_sync SHALL set a pending flag; when the FSM is in IDLE with the flag set, wr_bank SHALL toggle, wr_ofs SHALL clear and the flag SHALL clear, before any grant in that cycle.
REQ-027 A frame_sync edge during a burst SHALL be deferred, not lost; a second edge while the flag is still pending SHALL be absorbed into it.
REQ-028 Offset arithmetic SHALL be 21-bit unsigned with an explicit wrap compare; no carry into the bank bit.

Reset
REQ-029 While rst is high: state = IDLE; sys_wr_req = 0, sys_rd_req = 0, busy = 0, sys_addr = 0; wr_bank = 0, rd_bank = 1; wr_ofs = 0, rd_ofs = 0; pending flag = 0; last-grant = read.
REQ-030 Reset asserted mid-burst SHALL abort the burst immediately; after release the block SHALL restart from the reset values.

Verification
REQ-031 Scenario: wrf_use = 160, rdf_use = 400 -> sys_wr_req high with sys_addr = 0; after ack and done, next write at sys_addr = 160.
REQ-032 Scenario: wrf_use = 200 and rdf_use = 10 at the same time -> read granted first at {1, 0}.
REQ-033 Scenario: wrf_use = 300, rdf_use = 100, held -> grants alternate W, R, W, R.
REQ-034 Scenario: frame_sync rises during WR_WAIT -> that burst completes in bank 0; next write at {1, 0}.
REQ-035 Scenario: 480 write bursts with no frame_sync -> wr_ofs wraps to 0 and wr_bank is unchanged.
REQ-036 Scenario: rst pulsed while in RD_REQ -> all outputs 0 in the same cycle; after release the first grant matches REQ-031.
